float_add_arbiter: RTL

Two-requester round-robin arbiter and sequencer that shares one instance of the 8-bit mini-float adder (3-bit exponent, 5-bit mantissa) in the lab datapath. It latches one operand pair at a time and runs it through the adder. It registers the sum and returns it over a valid/ready result port tagged with the requester ID. Requesters use a level req / one-cycle ack handshake.

---
 rtl/float_add_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/float_add_arbiter.sv
// Two-requester round-robin front end for the shared 8-bit mini-float adder.
// One operand pair is latched per operation. The sum is registered and held
// on a valid/ready result port, tagged with the requester that owns it.
module float_add_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [7:0]       a0,
    input  logic [7:0]       b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [7:0]       a1,
    input  logic [7:0]       b1,
    output logic             ack1,
    output logic             res_valid,
    output logic [7:0]       res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       op_a_reg, op_a_next;
    logic [7:0]       op_b_reg, op_b_next;
    logic             gnt_id_reg, gnt_id_next;
    logic             last_grant_reg, last_grant_next;
    logic [7:0]       res_data_reg, res_data_next;
    logic             res_id_reg, res_id_next;
    logic             res_valid_reg, res_valid_next;
    logic             ack0_reg, ack0_next;
    logic             ack1_reg, ack1_next;
    logic [CNT_W-1:0] op_count_reg, op_count_next;

    // Shared adder datapath: operates on the latched operand registers.
    logic [7:0] big_op, small_op;
    logic [2:0] exp_diff;
    logic [5:0] man_sum;
    logic [7:0] add_sum;
    logic       grant_pick;

    // Mini-float add: align the smaller mantissa, add, saturate only at exp 7.
    // The carry out of the mantissa is dropped at lower exponents (no renormalise).
    always_comb begin
        if (op_a_reg >= op_b_reg) begin
            big_op   = op_a_reg;
            small_op = op_b_reg;
        end else begin
            big_op   = op_b_reg;
            small_op = op_a_reg;
        end
        exp_diff = big_op[7:5] - small_op[7:5];
        man_sum  = {1'b0, big_op[4:0]} + ({1'b0, small_op[4:0]} >> exp_diff);
        if (big_op[7:5] == 3'd7 && man_sum[5]) begin
            add_sum = 8'hFF;
        end else begin
            add_sum = {big_op[7:5], man_sum[4:0]};
        end
    end

    // Next-state and register-update logic; acks default low so they pulse once.
    always_comb begin
        state_next      = state_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        gnt_id_next     = gnt_id_reg;
        last_grant_next = last_grant_reg;
        res_data_next   = res_data_reg;
        res_id_next     = res_id_reg;
        res_valid_next  = res_valid_reg;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        op_count_next   = op_count_reg;
        grant_pick      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins.
                    grant_pick  = (req0 && req1) ? ~last_grant_reg : req1;
                    op_a_next   = grant_pick ? a1 : a0;
                    op_b_next   = grant_pick ? b1 : b0;
                    gnt_id_next = grant_pick;
                    state_next  = CALC;
                end
            end
            CALC: begin
                res_data_next  = add_sum;
                res_id_next    = gnt_id_reg;
                res_valid_next = 1'b1;
                ack0_next      = ~gnt_id_reg;
                ack1_next      = gnt_id_reg;
                state_next     = HOLD;
            end
            HOLD: begin
                if (res_valid_reg && res_ready) begin
                    res_valid_next  = 1'b0;
                    op_count_next   = op_count_reg + CNT_W'(1);
                    last_grant_next = gnt_id_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            op_a_reg       <= 8'h00;
            op_b_reg       <= 8'h00;
            gnt_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            res_data_reg   <= 8'h00;
            res_id_reg     <= 1'b0;
            res_valid_reg  <= 1'b0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            gnt_id_reg     <= gnt_id_next;
            last_grant_reg <= last_grant_next;
            res_data_reg   <= res_data_next;
            res_id_reg     <= res_id_next;
            res_valid_reg  <= res_valid_next;
            ack0_reg       <= ack0_next;
            ack1_reg       <= ack1_next;
            op_count_reg   <= op_count_next;
        end
    end

    assign ack0      = ack0_reg;
    assign ack1      = ack1_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign op_count  = op_count_reg;
    assign busy      = (state_reg != IDLE);

endmodule
